// File: rtl/kronos_if_stage_if.sv
// Kronos fetch-stage bus bundle.
// Instruction memory request/ack channel plus the IF->ID valid/ready channel.
//   instr_addr/instr_req     : fetch -> memory
//   instr_data/instr_ack     : memory -> fetch
//   fetch/pipe_out_vld       : fetch -> decode, fetch = {pc, ir}
//   pipe_out_rdy             : decode -> fetch
interface kronos_if_stage_if;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr_data;
  logic        instr_ack;
  logic [63:0] fetch;
  logic        pipe_out_vld;
  logic        pipe_out_rdy;

  modport master (
    output instr_addr,
    output instr_req,
    input  instr_data,
    input  instr_ack,
    output fetch,
    output pipe_out_vld,
    input  pipe_out_rdy
  );

  modport slave (
    input  instr_addr,
    input  instr_req,
    output instr_data,
    output instr_ack,
    input  fetch,
    input  pipe_out_vld,
    output pipe_out_rdy
  );
endinterface

// File: rtl/kronos_if_stage.sv
// Kronos RV32I instruction fetch stage.
// Fetches words over a req/ack bus, pairs them with their PC and hands
// {pc, ir} to decode over valid/ready, with a one-entry skid buffer and
// a branch redirect that flushes buffered and in-flight fetches.
// Ports: clk, rstz (async, active-high), bus (master side of
// kronos_if_stage_if), branch, branch_target, and fetch_misalign when
// KRONOS_IF_MISALIGN_EN is defined.
module kronos_if_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rstz,
  kronos_if_stage_if.master        bus,
  input  logic                     branch,
  input  logic [31:0]              branch_target
`ifdef KRONOS_IF_MISALIGN_EN
  ,
  output logic                     fetch_misalign
`endif
);

  typedef enum logic [1:0] {
    INIT,
    FETCH,
    STALL,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [63:0] fetch_q, fetch_d;
  logic        vld_q, vld_d;
  logic [63:0] skid_q, skid_d;

  logic        xfer;
  logic [31:0] tgt;
  logic [31:0] pc_inc;
  logic        req;
  logic [31:0] addr;

  assign xfer   = vld_q & bus.pipe_out_rdy;
  assign tgt    = branch_target & 32'hFFFF_FFFC;
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    fetch_d = fetch_q;
    vld_d   = vld_q & ~xfer;
    skid_d  = skid_q;
    req     = 1'b0;
    addr    = pc_q;
    case (state_q)
      INIT: begin
        state_d = FETCH;
        if (branch) pc_d = tgt;
      end
      FETCH: begin
        req = 1'b1;
        if (branch) begin
          pc_d  = tgt;
          vld_d = 1'b0;
          // keep the in-flight address alive until memory answers
          if (!bus.instr_ack) begin
            state_d = DRAIN;
            hold_d  = pc_q;
          end
        end else if (bus.instr_ack) begin
          pc_d = pc_inc;
          if (!vld_q || xfer) begin
            fetch_d = {pc_q, bus.instr_data};
            vld_d   = 1'b1;
          end else begin
            skid_d  = {pc_q, bus.instr_data};
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (branch) begin
          pc_d    = tgt;
          vld_d   = 1'b0;
          state_d = FETCH;
        end else if (xfer) begin
          fetch_d = skid_q;
          vld_d   = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        req  = 1'b1;
        addr = hold_q;
        if (branch) begin
          pc_d  = tgt;
          vld_d = 1'b0;
        end
        // returning word belongs to the abandoned path
        if (bus.instr_ack) state_d = FETCH;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rstz) begin
    if (rstz) begin
      state_q <= INIT;
      pc_q    <= BOOT_ADDR;
      hold_q  <= BOOT_ADDR;
      fetch_q <= '0;
      vld_q   <= 1'b0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      fetch_q <= fetch_d;
      vld_q   <= vld_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.instr_req    = req;
  assign bus.instr_addr   = addr;
  assign bus.fetch        = fetch_q;
  assign bus.pipe_out_vld = vld_q;

`ifdef KRONOS_IF_MISALIGN_EN
  logic mis_q;

  always_ff @(posedge clk or posedge rstz) begin
    if (rstz) mis_q <= 1'b0;
    else      mis_q <= branch & (|branch_target[1:0]);
  end

  assign fetch_misalign = mis_q;
`endif

endmodule

// File: tb/tb_kronos_if_stage.sv
// Self-checking bench for kronos_if_stage.
// Directed scenarios followed by a randomized run against a stream model.
module tb_kronos_if_stage;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstz;
  logic        branch;
  logic [31:0] branch_target;
`ifdef KRONOS_IF_MISALIGN_EN
  logic        fetch_misalign;
`endif

  kronos_if_stage_if bus ();

  kronos_if_stage #(.BOOT_ADDR(BOOT)) dut (
    .clk           (clk),
    .rstz          (rstz),
    .bus           (bus),
    .branch        (branch),
    .branch_target (branch_target)
`ifdef KRONOS_IF_MISALIGN_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail = 0;
  int          delivered = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, update the
  // delivered-stream model, then check bus/output hold rules.
  task automatic step(input logic a, input logic r,
                      input logic b, input logic [31:0] t);
    logic        pq, aq, vq;
    logic [31:0] adq;
    logic [63:0] fq;
    pq  = bus.instr_req;
    adq = bus.instr_addr;
    vq  = bus.pipe_out_vld;
    fq  = bus.fetch;
    aq  = a & pq;
    bus.instr_ack    = aq;
    bus.instr_data   = aq ? mem(adq) : 32'hDEAD_BEEF;
    bus.pipe_out_rdy = r;
    branch           = b;
    branch_target    = t;
    if (vq && r) begin
      chk("xfer", fq, {exp_pc, mem(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    if (b) exp_pc = {t[31:2], 2'b00};
    @(negedge clk);
    chk("addr_align", {62'd0, bus.instr_addr[1:0]}, 64'd0);
    if (pq && !aq) begin
      chk("req_hold", {63'd0, bus.instr_req}, 64'd1);
      chk("addr_hold", {32'd0, bus.instr_addr}, {32'd0, adq});
    end
    if (vq && !r && !b) begin
      chk("vld_hold", {63'd0, bus.pipe_out_vld}, 64'd1);
      chk("fetch_hold", bus.fetch, fq);
    end
    if (b) chk("br_vld", {63'd0, bus.pipe_out_vld}, 64'd0);
  endtask

  task automatic chk_bus(input string tag, input logic req,
                         input logic [31:0] addr, input logic vld);
    chk({tag, "_req"}, {63'd0, bus.instr_req}, {63'd0, req});
    chk({tag, "_addr"}, {32'd0, bus.instr_addr}, {32'd0, addr});
    chk({tag, "_vld"}, {63'd0, bus.pipe_out_vld}, {63'd0, vld});
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] pc);
    chk(tag, bus.fetch, {pc, mem(pc)});
  endtask

  task automatic do_reset();
    rstz = 1'b1;
    bus.instr_ack    = 1'b0;
    bus.instr_data   = '0;
    bus.pipe_out_rdy = 1'b0;
    branch           = 1'b0;
    branch_target    = '0;
    #1;
    chk_bus("rst", 1'b0, BOOT, 1'b0);
    chk("rst_fetch", bus.fetch, 64'd0);
`ifdef KRONOS_IF_MISALIGN_EN
    chk("rst_mis", {63'd0, fetch_misalign}, 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rstz      = 1'b0;
    exp_pc    = BOOT;
    delivered = 0;
  endtask

  initial begin
    rstz = 1'b1;
    @(negedge clk);
    do_reset();

    // streaming with same-cycle acks
    step(1'b0, 1'b1, 1'b0, '0);
    chk_bus("init", 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("s0", 32'h100);
    chk_bus("s0", 1'b1, 32'h104, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("s1", 32'h104);
    chk_bus("s1", 1'b1, 32'h108, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("s2", 32'h108);

    // reset while a request is outstanding
    do_reset();

    // decode stalls for five cycles
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk_pc("k0", 32'h100);
    chk_bus("k0", 1'b1, 32'h104, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0);
    chk_pc("k1", 32'h100);
    chk_bus("k1", 1'b0, 32'h108, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      chk("k_stall_req", {63'd0, bus.instr_req}, 64'd0);
    end
    chk_pc("k2", 32'h100);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("k3", 32'h104);
    chk_bus("k3", 1'b1, 32'h108, 1'b1);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("k4", 32'h108);
    step(1'b0, 1'b1, 1'b0, '0);
    chk_bus("k5", 1'b1, 32'h10C, 1'b0);
    chk("k_count", 64'(delivered), 64'd3);

    // slow memory, then a branch over the outstanding request
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk_bus("w", 1'b1, 32'h10C, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 32'h2000);
    chk_bus("d0", 1'b1, 32'h10C, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk_bus("d1", 1'b1, 32'h10C, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_bus("d2", 1'b1, 32'h2000, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("d3", 32'h2000);
    chk_bus("d3", 1'b1, 32'h2004, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk_bus("w2", 1'b1, 32'h2004, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("w3", 32'h2004);
    chk_bus("w3", 1'b1, 32'h2008, 1'b1);

    // branch colliding with an ack and a transfer
    step(1'b1, 1'b1, 1'b1, 32'h3000);
    chk_bus("c0", 1'b1, 32'h3000, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("c1", 32'h3000);

    // PC wraps at the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFB);
    chk_bus("z0", 1'b1, 32'hFFFF_FFF8, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_pc("z1", 32'h0);
    chk_bus("z1", 1'b1, 32'h4, 1'b1);

`ifdef KRONOS_IF_MISALIGN_EN
    step(1'b1, 1'b1, 1'b1, 32'h2002);
    chk("m0", {63'd0, fetch_misalign}, 64'd1);
    chk_bus("m0", 1'b1, 32'h2000, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("m1", {63'd0, fetch_misalign}, 64'd0);
    chk_pc("m1", 32'h2000);
`endif

    // randomized traffic against the stream model
    delivered = 0;
    for (int i = 0; i < 400; i++) begin
      logic        ra, rr, rb;
      logic [31:0] rt;
      ra = ($urandom_range(0, 9) < 6);
      rr = ($urandom_range(0, 9) < 7);
      rb = ($urandom_range(0, 24) == 0);
      rt = $urandom;
      step(ra, rr, rb, rt);
    end
    chk("progress", {63'd0, (delivered > 40)}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/kronos_if_stage.md
Name: kronos_if_stage

Overview:
Instruction fetch stage of the Kronos RV32I core, directly upstream of kronos_ID.
- Issues word reads on the instruction memory bus using a request/acknowledge handshake.
- Pairs each returned word with its PC and presents the pair as a pipeIFID_t to decode over a valid/ready handshake.
- Accepts a one-cycle branch redirect that flushes buffered and in-flight fetches.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
clk  in  1  core clock; all state updates on rising edge
rstz  in  1  reset; asynchronous, active-high (asserted when 1)
instr_addr  out  32  fetch address; always word-aligned
instr_req  out  1  fetch request
instr_data  in  32  instruction word; valid in a cycle with instr_ack=1
instr_ack  in  1  request completes this cycle; zero or more cycles after req
fetch  out  64  pipeIFID_t {pc[31:0], ir[31:0]}
pipe_out_vld  out  1  fetch holds a valid instruction
pipe_out_rdy  in  1  decode accepts fetch this cycle
branch  in  1  redirect pulse from execute/writeback
branch_target  in  32  new PC; sampled when branch=1

Behaviour:
- Reset values:
  - pc = BOOT_ADDR.
  - state = INIT.
  - instr_req = 0.
  - instr_addr = BOOT_ADDR.
  - fetch = 0.
  - pipe_out_vld = 0.
  - skid register empty.
- Bus rule: once instr_req=1, instr_addr and instr_req are held stable until the cycle in which instr_ack=1.
- Output rule: once pipe_out_vld=1, fetch and vld are held until pipe_out_rdy=1. A branch is the only exception.
- Transfer: a transfer to decode occurs on a cycle with pipe_out_vld && pipe_out_rdy.
- FSM:
  - INIT: one idle cycle after reset release, then go to FETCH.
  - FETCH: instr_req=1, instr_addr=pc. On ack:
    - Output register free (vld=0 or transfer this cycle): fetch <= {pc, instr_data}, vld <= 1, pc <= pc+4, stay in FETCH. Back-to-back acks give one instruction per cycle.
    - Output register occupied and not transferring: skid <= {pc, instr_data}, pc <= pc+4, go to STALL.
  - STALL: instr_req=0. On transfer: fetch <= skid, vld stays 1, skid emptied, go to FETCH.
  - DRAIN: entered on a branch while a request is outstanding (req=1, ack=0). Keep req and the old addr until ack, discard that data, then go to FETCH.
- Branch, when branch=1 in any state other than INIT:
  - pc <= branch_target; the old PC is not incremented.
  - pipe_out_vld <= 0 and the skid buffer is emptied.
  - Any instr_data acked in the same cycle is discarded.
  - Next state: DRAIN if a request is outstanding; otherwise FETCH.
  - A transfer in the branch cycle still completes; decode owns that instruction.
  - A branch in DRAIN updates pc again and stays in DRAIN.
  - A branch in INIT updates pc; the state still goes to FETCH.
- Latency: first request one cycle after INIT. With a same-cycle ack, vld rises the cycle after the ack.
- PC arithmetic: 32-bit modular. 32'hFFFF_FFFC + 4 wraps to 0.
- branch_target[1:0] is ignored; forced to 2'b00.
- Reset asserted mid-transaction: all state returns to reset values immediately. The pending bus request is abandoned (the memory must tolerate this).

Optional Feature:
Macro: KRONOS_IF_MISALIGN_EN.
- Defined:
  - Adds output port fetch_misalign (1 bit, reset 0).
  - Asserts for exactly one cycle, the cycle after a branch with branch_target[1:0] != 0.
  - The redirect itself proceeds normally with the low bits forced to 0.
- Undefined: the port is absent and misaligned low bits are silently dropped.

Test Plan:
- Reset, BOOT_ADDR=32'h100, memory acks same cycle, pipe_out_rdy=1 -> instr_addr 100,104,108 on consecutive cycles; fetch.pc follows one cycle later with matching ir; vld stays 1.
- pipe_out_rdy=0 for 5 cycles after the first instruction at 32'h100 -> second word captured in skid, instr_req=0, fetch held at pc 100; on rdy=1 the pcs 100,104,108 are delivered in order with none lost or duplicated.
- Memory ack delayed 3 cycles -> instr_addr and instr_req stable throughout; vld low until the cycle after the ack.
- branch=1, branch_target=32'h2000 while req is outstanding at 32'h10C, ack 2 cycles later -> vld drops next cycle; 10C data never appears on fetch; next instr_addr is 2000; fetch.pc=2000.
- branch in the same cycle as an ack and a transfer -> the transferred instruction counts as delivered; the acked word is dropped; pc=target.
- With KRONOS_IF_MISALIGN_EN defined, branch_target=32'h2002 -> fetch_misalign=1 for one cycle; instr_addr=32'h2000.
